// File: rtl/keypad_responder_pkg.sv
// Shared definitions for the keypad responder: register map, CTRL bits,
// matrix geometry and the row-scan state encoding.
package keypad_responder_pkg;

  localparam int DEVICE_NUM_KB_ROW = 4;
  localparam int DEVICE_NUM_KB_COL = 4;
  localparam int KP_ROWS           = DEVICE_NUM_KB_ROW;
  localparam int KP_COLS           = DEVICE_NUM_KB_COL;
  localparam int KP_KEYS           = KP_ROWS * KP_COLS;

  localparam logic [1:0] KP_REG_DATA   = 2'd0;
  localparam logic [1:0] KP_REG_STATUS = 2'd1;
  localparam logic [1:0] KP_REG_CTRL   = 2'd2;

  localparam int KP_CTRL_ENABLE_BIT  = 0;
  localparam int KP_CTRL_OVF_CLR_BIT = 1;

  typedef enum logic [1:0] {
    ROW0 = 2'd0,
    ROW1 = 2'd1,
    ROW2 = 2'd2,
    ROW3 = 2'd3
  } scan_state_e;

  function automatic scan_state_e kp_next_row(input scan_state_e s);
    scan_state_e n;
    case (s)
      ROW0:    n = ROW1;
      ROW1:    n = ROW2;
      ROW2:    n = ROW3;
      ROW3:    n = ROW0;
      default: n = ROW0;
    endcase
    return n;
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [3:0] kp_lowest_key(input logic [KP_KEYS-1:0] v);
    logic [3:0] k;
    k = 4'd0;
    for (int i = KP_KEYS - 1; i >= 0; i--) begin
      if (v[i]) begin
        k = 4'(i);
      end else begin
        k = k;
      end
    end
    return k;
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Parameterised synchronous FIFO for key codes; a push into a full FIFO
// is dropped and flagged unless a pop frees a slot on the same edge.
module keypad_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == CW'(0));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Pop only when data is present; a push may use the slot a pop frees.
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    dropped   = push & full & ~do_pop_s;
    wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

endmodule

// File: rtl/keypad_responder.sv
// 4x4 keypad bus responder: row scanning, full-matrix debounce, key-press
// FIFO and a DATA/STATUS/CTRL register interface.
module keypad_responder
  import keypad_responder_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [3:0]  col_signal,
  output logic [3:0]  row_en
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);

  scan_state_e        state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [KP_KEYS-1:0] snap_q, snap_d;
  logic [KP_KEYS-1:0] prev_q, prev_d;
  logic [KP_KEYS-1:0] deb_q, deb_d;
  logic [STB_W-1:0]   stb_q, stb_d;
  logic               enable_q, enable_d;
  logic               ovf_q, ovf_d;
  logic [3:0]         row_en_q, row_en_d;

  logic               rd_s, wr_s, pop_s, ctrl_wr_s;
  logic [1:0]         reg_sel_s;
  logic               push_s;
  logic [3:0]         push_code_s;
  logic [3:0]         fifo_head_s;
  logic               fifo_full_s, fifo_empty_s, fifo_drop_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic [31:0]        cnt_ext_s;
  logic [2:0]         stat_cnt_s;
  logic               unused_bits_s;

  assign rd_s          = sel & re;
  assign wr_s          = sel & we;
  assign reg_sel_s     = addr[3:2];
  assign pop_s         = rd_s & (reg_sel_s == KP_REG_DATA);
  assign ctrl_wr_s     = wr_s & (reg_sel_s == KP_REG_CTRL);
  assign row_en        = row_en_q;
  assign unused_bits_s = ^{wdata[31:2], addr[1:0]};

  // Row scan, snapshot capture and debounce; a push fires only when the
  // debounced vector is (re)loaded with a new lowest key.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    snap_d      = snap_q;
    prev_d      = prev_q;
    deb_d       = deb_q;
    stb_d       = stb_q;
    push_s      = 1'b0;
    push_code_s = 4'd0;
    if (enable_q) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        snap_d[{state_q, 2'b00} +: KP_COLS] = ~col_signal;
        state_d = kp_next_row(state_q);
        if (state_q == ROW3) begin
          if (snap_d == prev_q) begin
            stb_d = (stb_q == STB_MAX) ? stb_q : stb_q + STB_W'(1);
          end else begin
            stb_d = '0;
          end
          prev_d = snap_d;
          if ((stb_q != STB_MAX) && (stb_d == STB_MAX)) begin
            deb_d       = snap_d;
            push_code_s = kp_lowest_key(snap_d);
            push_s      = (snap_d != '0) &&
                          ((deb_q == '0) || (push_code_s != kp_lowest_key(deb_q)));
          end else begin
            deb_d = deb_q;
          end
        end else begin
          prev_d = prev_q;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else begin
      div_d = div_q;
    end
  end

  // CTRL writes; an overflowing push in the same cycle beats the clear.
  always_comb begin
    enable_d = enable_q;
    ovf_d    = ovf_q;
    if (ctrl_wr_s) begin
      enable_d = wdata[KP_CTRL_ENABLE_BIT];
      ovf_d    = wdata[KP_CTRL_OVF_CLR_BIT] ? 1'b0 : ovf_q;
    end else begin
      enable_d = enable_q;
    end
    if (fifo_drop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
    row_en_d = enable_d ? ~(4'b0001 << state_d) : 4'hF;
  end

  // Read mux; STATUS count field saturates at 7.
  always_comb begin
    cnt_ext_s  = 32'(fifo_count_s);
    stat_cnt_s = (cnt_ext_s > 32'd7) ? 3'd7 : cnt_ext_s[2:0];
    rdata      = 32'h0;
    if (rd_s) begin
      case (reg_sel_s)
        KP_REG_DATA:   rdata = {27'h0, ~fifo_empty_s,
                                (fifo_empty_s ? 4'd0 : fifo_head_s)};
        KP_REG_STATUS: rdata = {24'h0, ovf_q, stat_cnt_s, 3'b000, fifo_full_s};
        KP_REG_CTRL:   rdata = {30'h0, ovf_q, enable_q};
        default:       rdata = 32'h0;
      endcase
    end else begin
      rdata = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ROW0;
      div_q    <= '0;
      snap_q   <= '0;
      prev_q   <= '0;
      deb_q    <= '0;
      stb_q    <= '0;
      enable_q <= 1'b1;
      ovf_q    <= 1'b0;
      row_en_q <= 4'b1110;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      snap_q   <= snap_d;
      prev_q   <= prev_d;
      deb_q    <= deb_d;
      stb_q    <= stb_d;
      enable_q <= enable_d;
      ovf_q    <= ovf_d;
      row_en_q <= row_en_d;
    end
  end

  keypad_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_code_s),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s),
    .dropped   (fifo_drop_s)
  );

endmodule

// File: tb/tb_keypad_responder.sv
// Scoreboard bench for keypad_responder: a keypad matrix model drives the
// columns, expected key codes are queued on press and checked on DATA reads.
module tb_keypad_responder;
  import keypad_responder_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEPTH    = 4;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst, sel, we, re;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata;
  logic [3:0]  col_signal, row_en;
  logic [15:0] pressed;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [3:0]  exp_q[$];
  logic        model_ovf;

  always #5 clk = ~clk;

  keypad_responder #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (4),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .we         (we),
    .re         (re),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .col_signal (col_signal),
    .row_en     (row_en)
  );

  // Passive matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_signal = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_en[r] && pressed[r*4+c]) col_signal[c] = 1'b0;
      end
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, got, exp);
  endtask

  function automatic void sb_push(input logic [3:0] k);
    if (exp_q.size() < DEPTH) exp_q.push_back(k);
    else model_ovf = 1'b1;
  endfunction

  function automatic logic [31:0] sb_pop_data();
    if (exp_q.size() == 0) return 32'h0;
    return {27'h0, 1'b1, exp_q.pop_front()};
  endfunction

  function automatic logic [31:0] sb_status();
    int n = exp_q.size();
    return {24'h0, model_ovf, 3'((n > 7) ? 7 : n), 3'b000, (n == DEPTH)};
  endfunction

  task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; re = 1'b1; we = 1'b0; addr = {r, 2'b00};
    #1 d = rdata;
    @(negedge clk);
    sel = 1'b0; re = 1'b0; addr = 4'h0;
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [31:0] v);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; re = 1'b0; addr = {r, 2'b00}; wdata = v;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; addr = 4'h0; wdata = 32'h0;
  endtask

  task automatic check_data(input string tag);
    logic [31:0] d;
    bus_read(KP_REG_DATA, d);
    check_value(tag, d, sb_pop_data());
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    bus_read(KP_REG_STATUS, d);
    check_value(tag, d, sb_status());
  endtask

  task automatic wait_scans(input int n);
    repeat (n * SCAN_CYC) @(negedge clk);
  endtask

  task automatic press_release(input int k);
    pressed = 16'h0001 << k;
    sb_push(4'(k));
    wait_scans(7);
    pressed = 16'h0;
    wait_scans(7);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [3:0]  seq [5];
    logic [31:0] d, e;
    seq = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
    rst = 1'b1; sel = 1'b0; we = 1'b0; re = 1'b0;
    addr = 4'h0; wdata = 32'h0; pressed = 16'h0; model_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle scan sequence and empty reads.
    check_value("row_en_reset", 32'(row_en), 32'(seq[0]));
    for (int i = 1; i < 5; i++) begin
      repeat (SCAN_DIV) @(negedge clk);
      check_value("row_en_seq", 32'(row_en), 32'(seq[i]));
    end
    check_data("idle_data");
    check_status("idle_status");

    // Held key 6 pushes exactly once.
    pressed = 16'h0040;
    sb_push(4'd6);
    wait_scans(7);
    check_data("held_key6");
    check_data("held_key6_second");
    pressed = 16'h0;
    wait_scans(7);
    check_status("held_key6_status");

    // Bouncing key never settles.
    for (int i = 0; i < 10; i++) begin
      pressed[0] = ~pressed[0];
      wait_scans(1);
    end
    pressed = 16'h0;
    wait_scans(7);
    check_status("bounce_status");
    check_data("bounce_data");

    // Overflow with five presses into a four-entry FIFO.
    for (int k = 1; k <= 5; k++) press_release(k);
    check_status("ovf_status");
    for (int i = 0; i < 5; i++) check_data("ovf_drain");

    // Overflow clear, disable, ignored press, resume.
    bus_write(KP_REG_CTRL, 32'h2);
    model_ovf = 1'b0;
    check_status("ovf_cleared");
    bus_read(KP_REG_CTRL, d);
    check_value("ctrl_disabled", d, 32'h0);
    bus_write(KP_REG_CTRL, 32'h0);
    check_value("row_en_disabled", 32'(row_en), 32'hF);
    pressed = 16'h0200;
    wait_scans(7);
    check_value("row_en_still_off", 32'(row_en), 32'hF);
    check_status("disabled_press");
    pressed = 16'h0;
    bus_write(KP_REG_CTRL, 32'h1);
    check_value("row_en_resumed", 32'(row_en != 4'hF), 32'h1);
    press_release(9);
    check_data("resumed_key9");

    // Full FIFO: DATA read on the same edge as a new push.
    for (int k = 10; k <= 13; k++) press_release(k);
    for (int i = 0; i < 200 && row_en !== 4'h7; i++) @(negedge clk);
    check_value("sync_row3", 32'(row_en), 32'h7);
    for (int i = 0; i < 200 && row_en !== 4'hE; i++) @(negedge clk);
    check_value("sync_row0", 32'(row_en), 32'hE);
    pressed = 16'h4000;
    repeat (5 * SCAN_CYC - 1) @(negedge clk);
    sel = 1'b1; re = 1'b1; addr = {KP_REG_DATA, 2'b00};
    #1 d = rdata;
    e = sb_pop_data();
    sb_push(4'd14);
    check_value("coincident_read", d, e);
    @(negedge clk);
    sel = 1'b0; re = 1'b0; addr = 4'h0;
    pressed = 16'h0;
    wait_scans(7);
    check_status("coincident_status");
    for (int i = 0; i < 5; i++) check_data("coincident_order");

    // Reset in the middle of a scan and a DATA access.
    pressed = 16'h0008;
    sb_push(4'd3);
    wait_scans(7);
    repeat (5) @(negedge clk);
    sel = 1'b1; re = 1'b1; addr = {KP_REG_DATA, 2'b00}; rst = 1'b1;
    @(negedge clk);
    sel = 1'b0; re = 1'b0; addr = 4'h0; rst = 1'b0;
    exp_q.delete();
    model_ovf = 1'b0;
    check_value("row_en_after_rst", 32'(row_en), 32'hE);
    check_status("status_after_rst");
    check_data("data_after_rst");
    bus_read(KP_REG_CTRL, d);
    check_value("ctrl_after_rst", d, 32'h1);
    pressed = 16'h0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
